// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu control unit: FSM states, opcodes, ALU function
// selects and PC update controls.
package mycpu_pkg;

  typedef enum logic [3:0] {
    S_RST = 4'd0,
    S_INF = 4'd1,
    S_EX0 = 4'd2,
    S_XL1 = 4'd3,
    S_HLT = 4'd4
  } cu_state_t;

  // 0x00-0x0F are ALU register ops whose low nibble is the function select
  typedef enum logic [6:0] {
    OP_INC = 7'h01,
    OP_ADD = 7'h02,
    OP_MUL = 7'h07,
    OP_LD  = 7'h10,
    OP_IOR = 7'h11,
    OP_ST  = 7'h20,
    OP_IOW = 7'h21,
    OP_XXL = 7'h30,
    OP_ADI = 7'h42,
    OP_LDI = 7'h4C,
    OP_BRZ = 7'h60,
    OP_BRN = 7'h61,
    OP_JMP = 7'h70,
    OP_HAL = 7'h7F
  } opcode_t;

  typedef enum logic [3:0] {
    FMOVA = 4'h0,
    FINC  = 4'h1,
    FADD  = 4'h2,
    FSUB  = 4'h5,
    FDEC  = 4'h6,
    FMUL  = 4'h7,
    FAND  = 4'h8,
    FOR   = 4'h9,
    FXOR  = 4'hA,
    FNOT  = 4'hB,
    FMOVB = 4'hC,
    FSHR  = 4'hD,
    FSHL  = 4'hE
  } fs_t;

  typedef enum logic [1:0] {
    PC_NOP = 2'd0,
    PC_INC = 2'd1,
    PC_BRA = 2'd2,
    PC_JMP = 2'd3
  } pc_t;

endpackage

// File: rtl/mycpu_pc.sv
// Program counter register: hold, increment, relative branch or absolute jump,
// all modulo 2^AW.
module mycpu_pc
  import mycpu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  pc_t           ctl,
  input  logic [AW-1:0] off,
  input  logic [AW-1:0] tgt,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    case (ctl)
      PC_INC:  pc_d = pc_q + AW'(1);
      PC_BRA:  pc_d = pc_q + off;
      PC_JMP:  pc_d = tgt;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/mycpu_cu.sv
// Multi-cycle control unit: fetch/execute sequencing, strobe decode, PC control.
// Define MYCPU_ILLEGAL_TRAP_EN to trap undefined opcodes into HLT with illegal_out set.
module mycpu_cu
  import mycpu_pkg::*;
#(
  parameter int AW      = 8,
  parameter int RW      = 3,
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [7+3*RW-1:0]   ins_in,
  output logic                dmem_req,
  input  logic                dmem_ack,
  input  logic [AW-1:0]       a_in,
  input  logic                z_in,
  input  logic                n_in,
  output logic [AW-1:0]       pc_out,
  output logic [RW-1:0]       da_out,
  output logic [RW-1:0]       aa_out,
  output logic [RW-1:0]       ba_out,
  output fs_t                 fs_out,
  output logic                mb_out,
  output logic                md_out,
  output logic                rf_we,
  output logic                mem_we,
  output logic                io_out,
  output cu_state_t           state_out,
  output logic                illegal_out
);

  localparam int IW = 7 + 3*RW;
  localparam int CW = (RW > 4) ? RW : 4;

  cu_state_t     state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pc_t           pc_ctl;
  logic [6:0]    op;
  logic [AW-1:0] br_off;
`ifdef MYCPU_ILLEGAL_TRAP_EN
  logic          ill_q, ill_d;
`endif

  // Branch displacement {DR,SB} is a two's-complement field
  function automatic logic [AW-1:0] sext_off(input logic signed [2*RW-1:0] v);
    return AW'(v);
  endfunction

  assign op        = ir_q[IW-1:IW-7];
  assign da_out    = ir_q[3*RW-1:2*RW];
  assign aa_out    = ir_q[2*RW-1:RW];
  assign ba_out    = ir_q[RW-1:0];
  assign br_off    = sext_off({da_out, ba_out});
  assign state_out = state_q;
`ifdef MYCPU_ILLEGAL_TRAP_EN
  assign illegal_out = ill_q;
`else
  assign illegal_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    pc_ctl   = PC_NOP;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    fs_out   = FMOVA;
    mb_out   = 1'b0;
    md_out   = 1'b0;
    rf_we    = 1'b0;
    mem_we   = 1'b0;
    io_out   = 1'b0;
`ifdef MYCPU_ILLEGAL_TRAP_EN
    ill_d    = ill_q;
`endif
    case (state_q)
      S_RST: state_d = S_INF;
      S_INF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = ins_in;
          state_d = S_EX0;
        end
      end
      S_EX0: begin
        case (op)
          OP_MUL: begin
            fs_out = FMUL;
            if (MUL_LAT == 1) begin
              rf_we   = 1'b1;
              pc_ctl  = PC_INC;
              state_d = S_INF;
            end else begin
              cnt_d   = CW'(MUL_LAT - 2);
              state_d = S_XL1;
            end
          end
          OP_LDI, OP_ADI: begin
            fs_out  = fs_t'(op[3:0]);
            mb_out  = 1'b1;
            rf_we   = 1'b1;
            pc_ctl  = PC_INC;
            state_d = S_INF;
          end
          OP_LD, OP_IOR: begin
            dmem_req = 1'b1;
            md_out   = 1'b1;
            io_out   = (op == OP_IOR);
            if (dmem_ack) begin
              rf_we   = 1'b1;
              pc_ctl  = PC_INC;
              state_d = S_INF;
            end
          end
          OP_ST, OP_IOW: begin
            dmem_req = 1'b1;
            mem_we   = 1'b1;
            io_out   = (op == OP_IOW);
            if (dmem_ack) begin
              pc_ctl  = PC_INC;
              state_d = S_INF;
            end
          end
          OP_BRZ: begin
            pc_ctl  = z_in ? PC_BRA : PC_INC;
            state_d = S_INF;
          end
          OP_BRN: begin
            pc_ctl  = n_in ? PC_BRA : PC_INC;
            state_d = S_INF;
          end
          OP_JMP: begin
            pc_ctl  = PC_JMP;
            state_d = S_INF;
          end
          OP_XXL: begin
            cnt_d   = CW'(ba_out);
            state_d = S_XL1;
          end
          OP_HAL: state_d = S_HLT;
          default: begin
            if (op[6:4] == 3'd0) begin
              fs_out  = fs_t'(op[3:0]);
              rf_we   = 1'b1;
              pc_ctl  = PC_INC;
              state_d = S_INF;
            end else begin
`ifdef MYCPU_ILLEGAL_TRAP_EN
              ill_d   = 1'b1;
              state_d = S_HLT;
`else
              pc_ctl  = PC_INC;
              state_d = S_INF;
`endif
            end
          end
        endcase
      end
      S_XL1: begin
        // cnt_q counts the remaining XL1 cycles after this one
        if (op == OP_MUL) fs_out = FMUL;
        if (cnt_q == '0) begin
          rf_we   = (op == OP_MUL);
          pc_ctl  = PC_INC;
          state_d = S_INF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      ir_q    <= '0;
      cnt_q   <= '0;
`ifdef MYCPU_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
`ifdef MYCPU_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  mycpu_pc #(.AW(AW)) u_pc (
    .clk (clk),
    .rst (rst),
    .ctl (pc_ctl),
    .off (br_off),
    .tgt (a_in),
    .pc  (pc_out)
  );

endmodule

// File: tb/tb_mycpu_cu.sv
// Table-driven bench for mycpu_cu with a PC scoreboard checked at each fetch.
module tb_mycpu_cu;
  import mycpu_pkg::*;

  localparam int AW = 8;
  localparam int RW = 3;
  localparam int IW = 7 + 3*RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_ack = 1'b0;
  logic [IW-1:0] ins_in = '0;
  logic          dmem_req, dmem_ack = 1'b0;
  logic [AW-1:0] a_in = '0;
  logic          z_in = 1'b0, n_in = 1'b0;
  logic [AW-1:0] pc_out;
  logic [RW-1:0] da_out, aa_out, ba_out;
  fs_t           fs_out;
  logic          mb_out, md_out, rf_we, mem_we, io_out, illegal_out;
  cu_state_t     state_out;

  always #5 clk = ~clk;

  mycpu_cu #(.AW(AW), .RW(RW), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ins_in(ins_in),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .a_in(a_in), .z_in(z_in), .n_in(n_in),
    .pc_out(pc_out), .da_out(da_out), .aa_out(aa_out), .ba_out(ba_out),
    .fs_out(fs_out), .mb_out(mb_out), .md_out(md_out), .rf_we(rf_we),
    .mem_we(mem_we), .io_out(io_out), .state_out(state_out),
    .illegal_out(illegal_out)
  );

  typedef struct {
    logic [IW-1:0] ins;
    int            iack;
    logic          z, n;
    logic [AW-1:0] a;
    int            ack_dly;
    logic [3:0]    fs;
    logic          mb, md, io, dreq, mwe, rfn;
    int            ncyc;
    logic [AW-1:0] npc;
  } vec_t;

  vec_t          tbl[20];
  logic [AW-1:0] pc_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] hpc;

  function automatic logic [IW-1:0] enc(input logic [6:0] op, input logic [RW-1:0] dr,
                                        input logic [RW-1:0] sa, input logic [RW-1:0] sb);
    return {op, dr, sa, sb};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits for INF, compares PC against the scoreboard, fetches with a delayed ack.
  task automatic fetch(input logic [IW-1:0] ins, input int dly);
    int n = 0;
    logic [AW-1:0] epc;
    while (state_out != S_INF && n < 50) begin
      tick();
      n++;
    end
    if (pc_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: no expected pc queued");
      epc = '0;
    end else begin
      epc = pc_q.pop_front();
    end
    chk("fetch_state", state_out, S_INF);
    for (int i = 0; i <= dly; i++) begin
      imem_ack = (i == dly);
      ins_in   = (i == dly) ? ins : ~ins;
      #1;
      chk("imem_req", imem_req, 1);
      chk("fetch_pc", pc_out, epc);
      chk("inf_strobes", {rf_we, mem_we, dmem_req, mb_out, md_out, io_out}, 0);
      tick();
    end
    imem_ack = 1'b0;
    chk("ex0_entry", state_out, S_EX0);
    chk("ir_fields", {da_out, aa_out, ba_out}, ins[3*RW-1:0]);
  endtask

  task automatic exec(input vec_t v);
    int k = 0;
    fetch(v.ins, v.iack);
    pc_q.push_back(v.npc);
    while ((state_out == S_EX0 || state_out == S_XL1) && k < 40) begin
      z_in = v.z; n_in = v.n; a_in = v.a;
      dmem_ack = (k >= v.ack_dly);
      #1;
      chk("fs_out", fs_out, v.fs);
      chk("mb_md_io", {mb_out, md_out, io_out}, {v.mb, v.md, v.io});
      chk("dreq_mwe", {dmem_req, mem_we}, {v.dreq, v.mwe});
      chk("rf_we", rf_we, (v.rfn && k == v.ncyc - 1));
      k++;
      tick();
    end
    dmem_ack = 1'b0; z_in = 1'b0; n_in = 1'b0;
    chk("exec_cycles", k, v.ncyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    //            ins                 iack z n a      ackd fs   mb md io dq mw rf ncyc npc
    tbl[0]  = '{16'h8455,             2, 0,0,8'h00, 0, 4'h2, 1,0,0,0,0,1, 1, 8'h01};
    tbl[1]  = '{enc(7'h02,3,1,2),     0, 0,0,8'h00, 0, 4'h2, 0,0,0,0,0,1, 1, 8'h02};
    tbl[2]  = '{enc(7'h4C,2,0,7),     0, 0,0,8'h00, 0, 4'hC, 1,0,0,0,0,1, 1, 8'h03};
    tbl[3]  = '{enc(7'h0E,6,6,0),     1, 0,0,8'h00, 0, 4'hE, 0,0,0,0,0,1, 1, 8'h04};
    tbl[4]  = '{enc(7'h10,4,1,0),     0, 0,0,8'h00, 2, 4'h0, 0,1,0,1,0,1, 3, 8'h05};
    tbl[5]  = '{enc(7'h11,4,1,0),     0, 0,0,8'h00, 0, 4'h0, 0,1,1,1,0,1, 1, 8'h06};
    tbl[6]  = '{enc(7'h20,0,1,2),     0, 0,0,8'h00, 1, 4'h0, 0,0,0,1,1,0, 2, 8'h07};
    tbl[7]  = '{enc(7'h21,0,1,2),     0, 0,0,8'h00, 0, 4'h0, 0,0,1,1,1,0, 1, 8'h08};
    tbl[8]  = '{enc(7'h07,5,1,2),     0, 0,0,8'h00, 0, 4'h7, 0,0,0,0,0,1, 3, 8'h09};
    tbl[9]  = '{enc(7'h30,0,0,2),     0, 0,0,8'h00, 0, 4'h0, 0,0,0,0,0,0, 4, 8'h0A};
    tbl[10] = '{enc(7'h61,0,0,3),     0, 0,1,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h0D};
    tbl[11] = '{enc(7'h61,0,0,3),     0, 1,0,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h0E};
    tbl[12] = '{enc(7'h70,0,4,0),     0, 0,0,8'h10, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h10};
    tbl[13] = '{enc(7'h60,7,0,6),     0, 1,0,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h0E};
    tbl[14] = '{enc(7'h70,0,4,0),     0, 0,0,8'h10, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h10};
    tbl[15] = '{enc(7'h60,7,0,6),     0, 0,1,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h11};
    tbl[16] = '{enc(7'h70,0,4,0),     0, 0,0,8'hFF, 0, 4'h0, 0,0,0,0,0,0, 1, 8'hFF};
    tbl[17] = '{enc(7'h01,1,1,0),     0, 0,0,8'h00, 0, 4'h1, 0,0,0,0,0,1, 1, 8'h00};
    tbl[18] = '{enc(7'h60,7,0,6),     0, 1,0,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'hFE};
    tbl[19] = '{enc(7'h61,0,0,3),     0, 0,1,8'h00, 0, 4'h0, 0,0,0,0,0,0, 1, 8'h01};

    // Reset state
    tick(); tick();
    chk("rst_state", state_out, S_RST);
    chk("rst_pc", pc_out, 0);
    chk("rst_reqs", {imem_req, dmem_req, rf_we, mem_we}, 0);
    chk("rst_illegal", illegal_out, 0);
    chk("rst_ir", {da_out, aa_out, ba_out}, 0);
    rst = 1'b0;
    tick();
    chk("rst_to_inf", state_out, S_INF);
    pc_q.push_back(8'h00);

    for (int i = 0; i < 20; i++) exec(tbl[i]);

    // Reset in the middle of an LD handshake
    fetch(enc(7'h10, 2, 3, 0), 0);
    dmem_ack = 1'b0;
    #1;
    chk("ld_abort_req", dmem_req, 1);
    chk("ld_abort_we1", rf_we, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("ld_abort_we2", rf_we, 0);
    tick();
    rst = 1'b0;
    chk("ld_abort_state", state_out, S_RST);
    chk("ld_abort_dreq", dmem_req, 0);
    chk("ld_abort_pc", pc_out, 0);
    chk("ld_abort_we3", rf_we, 0);
    dmem_ack = 1'b1;
    tick();
    chk("ld_abort_inf", state_out, S_INF);
    chk("ld_abort_late_ack", {rf_we, dmem_req}, 0);
    dmem_ack = 1'b0;
    pc_q.push_back(8'h00);

    // Undefined opcode 0x7D
    fetch(enc(7'h7D, 1, 1, 1), 0);
    chk("undef_ex0_strobes", {rf_we, mem_we, dmem_req, mb_out, md_out, io_out}, 0);
    chk("undef_ex0_fs", fs_out, 0);
    tick();
`ifdef MYCPU_ILLEGAL_TRAP_EN
    chk("undef_trap_state", state_out, S_HLT);
    chk("undef_trap_flag", illegal_out, 1);
    tick();
    chk("undef_trap_hold", illegal_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("undef_trap_clear", illegal_out, 0);
    tick();
    hpc = 8'h00;
`else
    chk("undef_nop_state", state_out, S_INF);
    chk("undef_nop_flag", illegal_out, 0);
    hpc = 8'h01;
`endif
    pc_q.push_back(hpc);

    // HAL: held in HLT while the acks toggle
    fetch(enc(7'h7F, 2, 5, 3), 0);
    chk("hal_ex0_strobes", {rf_we, mem_we, dmem_req, imem_req}, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      #1;
      chk("hlt_state", state_out, S_HLT);
      chk("hlt_reqs", {imem_req, dmem_req, rf_we, mem_we, mb_out, md_out, io_out}, 0);
      chk("hlt_pc", pc_out, hpc);
      chk("hlt_ir", {da_out, aa_out, ba_out}, {3'd2, 3'd5, 3'd3});
      tick();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    rst = 1'b1;
    tick();
    chk("final_rst_state", state_out, S_RST);
    chk("final_rst_pc", pc_out, 0);
    chk("final_rst_ir", {da_out, aa_out, ba_out}, 0);
    rst = 1'b0;
    tick();
    chk("final_inf", state_out, S_INF);
    chk("final_imem_req", imem_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mycpu_cu.md
MYCPU_CU -- requirements
Module: mycpu_cu

Interface
REQ-001 SHALL have parameter AW, default 8, PC/address width (legal 4..16).
REQ-002 SHALL have parameter RW, default 3, register-address field width; instruction width IW = 7+3*RW.
REQ-003 SHALL have parameter MUL_LAT, default 3, MUL execute cycles (legal 1..15).
REQ-004 SHALL have clk  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have imem_req out 1, imem_ack in 1, ins_in in IW: instruction-fetch handshake and fetched word.
REQ-007 SHALL have dmem_req out 1, dmem_ack in 1: data/IO access handshake.
REQ-008 SHALL have a_in  in  AW: register-A bus value, used as jump target.
REQ-009 SHALL have z_in, n_in  in  1 each: zero/negative status of bus A.
REQ-010 SHALL have pc_out out AW, plus da_out, aa_out, ba_out out RW each: PC and register addresses.
REQ-011 SHALL have fs_out out 4 (fs_t), mb_out out 1 (B = zero-extended SB immediate), md_out out 1 (write-back from memory), rf_we out 1, mem_we out 1, io_out out 1 (access targets IO).
REQ-012 SHALL have state_out out 4 (cu_state_t) and illegal_out out 1.

Function
REQ-013 IR fields SHALL be opcode = IR[IW-1:IW-7], then DR, SA, SB as consecutive RW-bit fields; da/aa/ba_out SHALL follow DR/SA/SB in every state.
REQ-014 INF: imem_req=1, pc_out = fetch address; in the cycle imem_ack=1, IR <= ins_in and next state EX0; imem_req held until ack; no other strobes.
REQ-015 EX0, opcodes 0x00-0x0F (except MUL), LDI, ADI: fs_out = opcode[3:0], rf_we=1 for exactly one cycle, mb_out=1 for LDI/ADI, PC+1, then INF.
REQ-016 LD/IOR: dmem_req=1, md_out=1, io_out=1 for IOR; stay in EX0 until dmem_ack; rf_we=1 in the ack cycle only; then PC+1 and INF.
REQ-017 ST/IOW: dmem_req=1 and mem_we=1 held until dmem_ack; PC+1 on ack; rf_we=0.
REQ-018 BRZ/BRN: one cycle; if z_in (BRZ) or n_in (BRN) then PC += sign-extended {DR,SB} (2*RW bits), else PC+1.
REQ-019 JMP: PC <= a_in, one cycle.
REQ-020 MUL: fs_out=FMUL for MUL_LAT cycles (EX0 then XL1 x MUL_LAT-1); rf_we only in the last cycle; MUL_LAT=1 completes in EX0.
REQ-021 XXL: EX0 then XL1 for SB+1 cycles with all strobes 0, then PC+1 and INF.
REQ-022 HAL: enter HLT; HLT holds PC/IR, all strobes and reqs 0, exits only via rst.
REQ-023 PC arithmetic SHALL be modulo 2^AW (AW=8: 0xFF+1 = 0x00; branch wraps likewise).
REQ-024 imem_ack/dmem_ack SHALL be ignored while the matching req is 0.
REQ-025 fs_out, rf_we, mb_out, md_out, mem_we, io_out SHALL be 0 outside EX0/XL1.

Reset
REQ-026 On rst=1 at a clock edge: state RST, PC=0, IR=0, cycle counter 0, illegal_out=0, all reqs/strobes 0.
REQ-027 rst mid-handshake SHALL abort it; reqs are 0 from the cycle after the rst edge, no write strobe issued.
REQ-028 First edge with rst=0: RST -> INF.

Configuration
REQ-029 With macro MYCPU_ILLEGAL_TRAP_EN defined: an undefined opcode in EX0 SHALL go to HLT and set illegal_out=1, held until rst.
REQ-030 Without MYCPU_ILLEGAL_TRAP_EN: an undefined opcode SHALL execute as NOP (PC+1, no strobes) and illegal_out SHALL be tied 0.

Structure
REQ-031 cu_state_t, opcode_t, fs_t and pc_t SHALL live in mycpu_pkg; no new package types are needed.
REQ-032 PC register SHALL be a sub-module mycpu_pc (parameter AW; pc_t control NOP/INC/BRA/JMP, offset and target inputs, sync reset).

Verification
REQ-033 Reset, then imem_ack delayed 2 cycles -> imem_req high 3 cycles, pc_out=0x00, IR latched on ack cycle, state EX0 next.
REQ-034 ADI 0x8455 (DR=1, SA=2, SB=5) -> fs_out=FADD, mb_out=1, rf_we one cycle, da=1, aa=2, ba=5, PC 0x00->0x01.
REQ-035 BRZ at PC=0x10, DR=7, SB=6 (offset -2) -> z_in=1: PC=0x0E; z_in=0: PC=0x11.
REQ-036 MUL, MUL_LAT=3 -> state EX0, XL1, XL1; fs_out=FMUL all 3 cycles; rf_we only in the 3rd; then INF.
REQ-037 LD, dmem_ack due after 4 cycles, rst asserted in cycle 2 -> next cycle state RST, dmem_req=0, PC=0, rf_we never 1.
REQ-038 INC at PC=0xFF -> PC=0x00; HAL -> HLT held 10 cycles despite toggling acks; opcode 0x7D with macro -> HLT, illegal_out=1; without -> PC+1.
